// File: rtl/rx_data_buffer.sv
// Byte FIFO between the USB receive engine and the AHB-side consumer; also latches the last non-data packet code.
// Latency: a read request returns its byte on rx_data one cycle later, qualified by an rx_data_valid pulse.
// Backpressure: none; writes while full are dropped (sticky overflow) and reads while empty are ignored (sticky underflow).
//
// Ports:
//   clk, n_rst                       clock and asynchronous active-low reset
//   store_rx_packet, rx_packet,      strobe, packet code and data byte from usb_rx
//   rx_packet_data
//   get_rx_data                      consumer read request, one byte per cycle
//   clear                            synchronous flush of contents and flags
//   rx_data, rx_data_valid           registered read data and its one-cycle valid pulse
//   buffer_occupancy                 bytes stored, 0..DEPTH
//   last_packet                      last non-data packet code received
//   overflow, underflow              sticky error flags
//   empty, full                      occupancy status
module rx_data_buffer #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     store_rx_packet,
  input  logic [2:0]               rx_packet,
  input  logic [7:0]               rx_packet_data,
  input  logic                     get_rx_data,
  input  logic                     clear,
  output logic [7:0]               rx_data,
  output logic                     rx_data_valid,
  output logic [$clog2(DEPTH):0]   buffer_occupancy,
  output logic [2:0]               last_packet,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  localparam logic [2:0] PKT_NONE = 3'b000;
  localparam logic [2:0] PKT_DATA = 3'b011;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [OW-1:0] occ;

  logic wr_req;
  logic rd_ok;
  logic wr_ok;
  logic code_load;

  assign empty            = (occ == '0);
  assign full             = (occ == OW'(DEPTH));
  assign buffer_occupancy = occ;

  assign wr_req    = store_rx_packet && (rx_packet == PKT_DATA);
  assign rd_ok     = get_rx_data && !empty;
  // When full, a same-cycle read frees the slot the write lands in
  // (wptr == rptr then, and the read samples the old contents).
  assign wr_ok     = wr_req && (!full || rd_ok) && !clear;
  assign code_load = store_rx_packet && (rx_packet != PKT_DATA) && (rx_packet != PKT_NONE);

  // Storage is not reset; pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= rx_packet_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr          <= '0;
      rptr          <= '0;
      occ           <= '0;
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      last_packet   <= PKT_NONE;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else if (clear) begin
      // rx_data deliberately holds its last value across a flush.
      wptr          <= '0;
      rptr          <= '0;
      occ           <= '0;
      rx_data_valid <= 1'b0;
      last_packet   <= PKT_NONE;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      rx_data_valid <= rd_ok;
      if (rd_ok) begin
        rx_data <= mem[rptr];
        rptr    <= rptr + AW'(1);
      end
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (wr_ok && !rd_ok) begin
        occ <= occ + OW'(1);
      end else if (!wr_ok && rd_ok) begin
        occ <= occ - OW'(1);
      end
      if (wr_req && full && !get_rx_data) begin
        overflow <= 1'b1;
      end
      if (get_rx_data && empty) begin
        underflow <= 1'b1;
      end
      if (code_load) begin
        last_packet <= rx_packet;
      end
    end
  end

endmodule

// File: tb/tb_rx_data_buffer.sv
// Self-checking bench for rx_data_buffer: vector table, directed corner sequences and a random run against a queue model.
// Latency: expects read data one cycle after a request.
// Backpressure: models dropped writes when full and ignored reads when empty.
module tb_rx_data_buffer;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       store_rx_packet;
  logic [2:0] rx_packet;
  logic [7:0] rx_packet_data;
  logic       get_rx_data;
  logic       clear;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic [6:0] buffer_occupancy;
  logic [2:0] last_packet;
  logic       overflow;
  logic       underflow;
  logic       empty;
  logic       full;

  rx_data_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .store_rx_packet  (store_rx_packet),
    .rx_packet        (rx_packet),
    .rx_packet_data   (rx_packet_data),
    .get_rx_data      (get_rx_data),
    .clear            (clear),
    .rx_data          (rx_data),
    .rx_data_valid    (rx_data_valid),
    .buffer_occupancy (buffer_occupancy),
    .last_packet      (last_packet),
    .overflow         (overflow),
    .underflow        (underflow),
    .empty            (empty),
    .full             (full)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural reference: a queue of stored bytes plus output state.
  logic [7:0] q[$];
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovf;
  logic       m_udf;
  logic [2:0] m_lp;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_lp    = 3'd0;
  endtask

  task automatic model_step(input logic st, input logic [2:0] pk, input logic [7:0] d,
                            input logic gt, input logic cl);
    bit was_full;
    if (cl) begin
      q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_lp    = 3'd0;
      m_valid = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      m_valid  = 1'b0;
      if (gt) begin
        if (q.size() > 0) begin
          m_data  = q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_udf = 1'b1;
        end
      end
      if (st && pk == 3'd3) begin
        if (!was_full || gt) q.push_back(d);
        else m_ovf = 1'b1;
      end else if (st && pk != 3'd0) begin
        m_lp = pk;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic st, input logic [2:0] pk, input logic [7:0] d,
                      input logic gt, input logic cl);
    store_rx_packet = st;
    rx_packet       = pk;
    rx_packet_data  = d;
    get_rx_data     = gt;
    clear           = cl;
    model_step(st, pk, d, gt, cl);
    @(posedge clk);
    #1;
    store_rx_packet = 1'b0;
    rx_packet       = 3'd0;
    rx_packet_data  = 8'h00;
    get_rx_data     = 1'b0;
    clear           = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".data"},  int'(rx_data),          int'(m_data));
    chk({tag, ".valid"}, int'(rx_data_valid),    int'(m_valid));
    chk({tag, ".occ"},   int'(buffer_occupancy), q.size());
    chk({tag, ".empty"}, int'(empty),            int'(q.size() == 0));
    chk({tag, ".full"},  int'(full),             int'(q.size() == DEPTH));
    chk({tag, ".ovf"},   int'(overflow),         int'(m_ovf));
    chk({tag, ".udf"},   int'(underflow),        int'(m_udf));
    chk({tag, ".lp"},    int'(last_packet),      int'(m_lp));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".data"},  int'(rx_data),          0);
    chk({tag, ".valid"}, int'(rx_data_valid),    0);
    chk({tag, ".occ"},   int'(buffer_occupancy), 0);
    chk({tag, ".empty"}, int'(empty),            1);
    chk({tag, ".full"},  int'(full),             0);
    chk({tag, ".ovf"},   int'(overflow),         0);
    chk({tag, ".udf"},   int'(underflow),        0);
    chk({tag, ".lp"},    int'(last_packet),      0);
  endtask

  typedef struct {
    logic       st;
    logic [2:0] pk;
    logic [7:0] d;
    logic       gt;
    logic       cl;
    int         occ;
    logic       vld;
    logic [7:0] dat;
    logic       ovf;
    logic       udf;
    logic [2:0] lp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [7:0] first;
    int         wr_pct;

    n_rst = 1'b0;
    store_rx_packet = 1'b0;
    rx_packet = 3'd0;
    rx_packet_data = 8'h00;
    get_rx_data = 1'b0;
    clear = 1'b0;
    model_reset();

    //          st pk    d      gt cl  occ vld dat    ovf udf lp
    tbl[0]  = '{1, 3'd3, 8'hA5, 0, 0,  1,  0, 8'h00, 0,  0,  3'd0};
    tbl[1]  = '{1, 3'd3, 8'h3C, 0, 0,  2,  0, 8'h00, 0,  0,  3'd0};
    tbl[2]  = '{1, 3'd3, 8'hFF, 0, 0,  3,  0, 8'h00, 0,  0,  3'd0};
    tbl[3]  = '{0, 3'd0, 8'h00, 1, 0,  2,  1, 8'hA5, 0,  0,  3'd0};
    tbl[4]  = '{0, 3'd0, 8'h00, 1, 0,  1,  1, 8'h3C, 0,  0,  3'd0};
    tbl[5]  = '{0, 3'd0, 8'h00, 1, 0,  0,  1, 8'hFF, 0,  0,  3'd0};
    tbl[6]  = '{0, 3'd0, 8'h00, 1, 0,  0,  0, 8'hFF, 0,  1,  3'd0};
    tbl[7]  = '{1, 3'd4, 8'h99, 0, 0,  0,  0, 8'hFF, 0,  1,  3'd4};
    tbl[8]  = '{0, 3'd0, 8'h00, 0, 1,  0,  0, 8'hFF, 0,  0,  3'd0};
    tbl[9]  = '{1, 3'd3, 8'h11, 1, 0,  1,  0, 8'hFF, 0,  1,  3'd0};
    tbl[10] = '{1, 3'd0, 8'h22, 0, 0,  1,  0, 8'hFF, 0,  1,  3'd0};
    tbl[11] = '{0, 3'd0, 8'h00, 1, 0,  0,  1, 8'h11, 0,  1,  3'd0};
    tbl[12] = '{0, 3'd0, 8'h00, 0, 0,  0,  0, 8'h11, 0,  1,  3'd0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    n_rst = 1'b1;

    // Vector table: basic FIFO, underflow, code latch, clear, empty read+write
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].st, tbl[i].pk, tbl[i].d, tbl[i].gt, tbl[i].cl);
      chk($sformatf("vec%0d.occ", i),   int'(buffer_occupancy), tbl[i].occ);
      chk($sformatf("vec%0d.valid", i), int'(rx_data_valid),    int'(tbl[i].vld));
      chk($sformatf("vec%0d.data", i),  int'(rx_data),          int'(tbl[i].dat));
      chk($sformatf("vec%0d.ovf", i),   int'(overflow),         int'(tbl[i].ovf));
      chk($sformatf("vec%0d.udf", i),   int'(underflow),        int'(tbl[i].udf));
      chk($sformatf("vec%0d.lp", i),    int'(last_packet),      int'(tbl[i].lp));
      chk($sformatf("vec%0d.empty", i), int'(empty),            int'(tbl[i].occ == 0));
    end

    // Fill to DEPTH, one extra write is dropped, read all back
    step(0, 3'd0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 3'd3, 8'(i * 3 + 1), 0, 0);
    step(1, 3'd3, 8'hEE, 0, 0);
    check_model("ovf_fill");
    chk("ovf_fill.full_const", int'(full), 1);
    chk("ovf_fill.occ_const", int'(buffer_occupancy), DEPTH);
    chk("ovf_fill.ovf_const", int'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 3'd0, 8'h00, 1, 0);
      check_model("ovf_drain");
      chk("ovf_drain.byte", int'(rx_data), (i * 3 + 1) & 8'hFF);
    end
    chk("ovf_drain.empty", int'(empty), 1);

    // Full buffer: simultaneous write and read, then a handshake code
    step(0, 3'd0, 8'h00, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 3'd3, 8'(8'h80 + i), 0, 0);
    first = 8'h80;
    step(1, 3'd3, 8'h77, 1, 0);
    check_model("full_rw");
    chk("full_rw.oldest", int'(rx_data), int'(first));
    chk("full_rw.occ", int'(buffer_occupancy), DEPTH);
    chk("full_rw.ovf", int'(overflow), 0);
    step(1, 3'd4, 8'h00, 0, 0);
    check_model("ack_code");
    chk("ack_code.lp", int'(last_packet), 4);
    chk("ack_code.occ", int'(buffer_occupancy), DEPTH);

    // Pointer wrap: fill 60, read 60, write 10, read 10
    step(0, 3'd0, 8'h00, 0, 1);
    for (int i = 0; i < 60; i++) step(1, 3'd3, 8'(i ^ 8'h5A), 0, 0);
    for (int i = 0; i < 60; i++) begin
      step(0, 3'd0, 8'h00, 1, 0);
      check_model("wrap_a");
    end
    for (int i = 0; i < 10; i++) step(1, 3'd3, 8'(8'hC0 + i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 3'd0, 8'h00, 1, 0);
      check_model("wrap_b");
      chk("wrap_b.byte", int'(rx_data), 8'hC0 + i);
    end
    chk("wrap.occ_end", int'(buffer_occupancy), 0);

    // Asynchronous reset mid-read with five bytes stored
    step(0, 3'd0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 3'd3, 8'(8'h50 + i), 0, 0);
    step(0, 3'd0, 8'h00, 1, 0);
    check_model("pre_rst");
    get_rx_data = 1'b1;
    #3;
    n_rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    get_rx_data = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_reset();
    step(1, 3'd3, 8'hC3, 0, 0);
    check_model("post_rst");
    chk("post_rst.entry0", int'(dut.mem[0]), 8'hC3);
    step(0, 3'd0, 8'h00, 1, 0);
    check_model("post_rst_rd");

    // Randomized traffic against the queue model, alternating fill/drain bias
    for (int i = 0; i < 2000; i++) begin
      logic       st;
      logic [2:0] pk;
      wr_pct = ((i / 250) % 2 == 0) ? 85 : 20;
      st = ($urandom_range(0, 99) < wr_pct);
      pk = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      step(st, pk, 8'($urandom), ($urandom_range(0, 99) >= wr_pct),
           ($urandom_range(0, 199) == 0));
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_data_buffer.md
RX_DATA_BUFFER -- requirements
Module: rx_data_buffer

Interface
REQ-001 Parameter DEPTH, default 64, SHALL be the number of byte entries; power of 2, 4 to 128.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 store_rx_packet  input  1  one-cycle strobe from usb_rx: rx_packet and rx_packet_data valid this cycle.
REQ-005 rx_packet  input  3  packet/token code from usb_rx (encoding in REQ-012).
REQ-006 rx_packet_data  input  8  received byte from usb_rx.
REQ-007 get_rx_data  input  1  read request from the AHB-side consumer; one byte per asserted cycle.
REQ-008 clear  input  1  synchronous flush of contents and flags.
REQ-009 rx_data  output  8  registered read data.
REQ-010 rx_data_valid  output  1  one-cycle pulse; rx_data holds a newly popped byte.
REQ-011 buffer_occupancy  output  $clog2(DEPTH)+1  bytes stored, 0..DEPTH; last_packet output 3 (latched last non-data code); overflow, underflow, empty, full outputs 1 each.

Function
REQ-012 rx_packet encoding SHALL be: 000 none, 001 OUT, 010 IN, 011 data byte, 100 ACK, 101 NAK, 110 STALL, 111 receive error.
REQ-013 store_rx_packet with rx_packet=011 SHALL be a write request for rx_packet_data.
REQ-014 store_rx_packet with rx_packet other than 011 or 000 SHALL load last_packet on the next edge; no write occurs.
REQ-015 store_rx_packet with rx_packet=000 SHALL be ignored.
REQ-016 Write, not full: mem[wptr] <= byte; wptr increments modulo DEPTH; occupancy +1.
REQ-017 Write, full, no read same cycle: byte dropped; overflow set, sticky until clear or reset.
REQ-018 Read, not empty: rx_data <= mem[rptr] and rx_data_valid=1 on next edge; rptr increments modulo DEPTH; occupancy -1.
REQ-019 Read, empty: rx_data holds; rx_data_valid=0; underflow set, sticky until clear or reset.
REQ-020 Read and write same cycle, not empty: both succeed; occupancy unchanged; valid when full (write uses the slot freed).
REQ-021 Read and write same cycle, empty: no bypass; write succeeds, underflow set, occupancy becomes 1.
REQ-022 Read latency SHALL be exactly one cycle; throughput one byte per cycle each direction.
REQ-023 empty SHALL equal (occupancy==0) and full (occupancy==DEPTH), both combinational from registered occupancy.
REQ-024 Pointers width $clog2(DEPTH); wrap from DEPTH-1 to 0 with no lost or duplicated byte.
REQ-025 Order SHALL be strict FIFO.
REQ-026 clear SHALL override read and write that cycle: pointers, occupancy, overflow, underflow, last_packet to 0; rx_data_valid 0 next cycle; rx_data holds; memory contents need not be cleared.
REQ-027 rx_data_valid SHALL be low every cycle without a successful read.

Reset
REQ-028 n_rst low SHALL immediately force: pointers 0, occupancy 0, rx_data 8'h00, rx_data_valid 0, last_packet 000, overflow 0, underflow 0; empty=1, full=0.
REQ-029 Reset mid-operation SHALL discard all stored bytes; first write after release goes to entry 0.
REQ-030 Memory array need not be reset.

Verification
REQ-031 Reset, then three data-byte stores 8'hA5, 8'h3C, 8'hFF -> occupancy 3; three reads -> rx_data A5, 3C, FF each one cycle after request with valid pulses; empty=1.
REQ-032 DEPTH stores (DEPTH=64) then one more -> full=1, occupancy 64, overflow=1, 65th byte absent on readback of all 64.
REQ-033 Read while empty -> underflow=1, no valid pulse; then clear -> underflow=0, occupancy 0.
REQ-034 Fill 60, read 60, write/read 10 more -> pointers wrap; data order preserved, occupancy 0 at end.
REQ-035 Full buffer, simultaneous store 8'h77 and read -> oldest byte returned, occupancy stays 64, overflow=0; store rx_packet=100 -> last_packet=100, occupancy unchanged.
REQ-036 n_rst asserted with occupancy 5 mid-read -> all outputs at REQ-028 values same cycle; next store lands at entry 0.
